fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Instruction-fetch stage: holds the PC register and drives the instruction-memory address.
- Captures fetched instructions into the IF/ID pipeline register.
- Consumes the branch unit's redirect (PcSel/BrPC) and flushes wrong-path instructions.
- Replaces the simulation-only halt stop with a synthesizable drain-then-halt sequence that asserts a sticky halted flag.

Parameters:
- PC_W, 9, width of the PC and instruction-memory byte address
- HALT_DRAIN, 2, cycles to drain the pipeline after halt_req before halted asserts (1..15)
- NOP_INSTR, 32'h00000013, instruction placed in IF/ID on flush/bubble (addi x0,x0,0)

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hazard-unit stall; hold PC and IF/ID
- PcSel  in  1  branch unit: redirect taken this cycle
- BrPC  in  32  branch unit: redirect target
- halt_req  in  1  decode saw halt instruction (level, sampled per cycle)
- instr_in  in  32  instruction memory read data for pc_out (combinational, same cycle)
- pc_out  out  PC_W  current PC / instruction-memory address
- if_id_pc  out  PC_W  PC of instruction held in IF/ID
- if_id_instr  out  32  instruction held in IF/ID
- if_id_valid  out  1  IF/ID holds a real (non-bubble) instruction
- halted  out  1  sticky: core has drained and stopped fetching
- fetch_count  out  32  count of valid instructions loaded into IF/ID

Behaviour:
- Reset (sync, highest priority): pc_out=0, if_id_pc=0, if_id_instr=NOP_INSTR, if_id_valid=0, halted=0, fetch_count=0, state=RUN, drain counter=0.
- States: RUN, DRAIN, HALTED.
- RUN priority, per cycle, highest first:
  1. PcSel=1: pc_out<=BrPC[PC_W-1:0] with bits[1:0] forced to 0; IF/ID<=bubble (NOP_INSTR, valid=0, if_id_pc<=0). Stall and halt_req are ignored (a halt_req in the same cycle is wrong-path).
  2. stall=1: pc_out, IF/ID and fetch_count hold. halt_req is not acted on while stalled.
  3. halt_req=1: state<=DRAIN, counter<=HALT_DRAIN; pc_out holds; IF/ID<=bubble.
  4. Otherwise: IF/ID<={pc_out, instr_in, valid=1}; pc_out<=pc_out+4, wrapping modulo 2^PC_W; fetch_count+1.
- Latency: the instruction at address A appears in IF/ID exactly one cycle after pc_out=A with no stall or redirect.
- DRAIN: pc_out holds, IF/ID holds the bubble, stall is ignored, and the counter decrements each cycle.
  - PcSel=1 in DRAIN: an older branch resolved, so the halt was wrong-path. Perform the redirect as in RUN (1) and return to RUN; the counter clears.
  - When the counter reaches 1 and PcSel=0: next state HALTED.
- HALTED: halted=1; pc_out, IF/ID and fetch_count frozen; all inputs ignored until reset.
- fetch_count wraps at 2^32.
- BrPC upper bits above PC_W are discarded.
- Reset asserted in any state, including mid-DRAIN, returns to the reset values on the next edge.

Test Plan:
- Reset then 4 free-running cycles with instr_in=0x11,0x22,0x33,0x44 -> pc_out 0,4,8,12,16; IF/ID (pc,instr)=(0,0x11),(4,0x22),(8,0x33),(12,0x44); fetch_count=4.
- At pc_out=8 assert PcSel with BrPC=0x40 -> next cycle pc_out=0x40, if_id_valid=0, if_id_instr=0x00000013; the following cycle fetches from 0x40.
- Assert stall and PcSel together at pc_out=12 with BrPC=0x20 -> pc_out=0x20 (redirect wins); with stall alone for 3 cycles -> pc_out and IF/ID unchanged, fetch_count unchanged.
- halt_req at pc_out=0x10 with HALT_DRAIN=2 -> DRAIN for 2 cycles, pc_out stays 0x10, then halted=1 held 10 cycles regardless of PcSel/stall; reset clears halted and pc_out=0.
- halt_req, then PcSel in the first DRAIN cycle with BrPC=0x30 -> halted stays 0, pc_out=0x30, normal fetch resumes.
- PC_W=9 wrap: run from pc_out=0x1FC -> next pc_out=0x000. Redirect BrPC=0x00000207 -> pc_out=0x004.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// -----------------------------------------------------------------------------
// fetch_pc_unit
//
// Instruction-fetch stage. Owns the PC register that addresses instruction
// memory, captures the returned instruction into the IF/ID pipeline register,
// applies branch redirects (flushing the wrong-path fetch), and performs a
// drain-then-halt sequence when decode reports a halt instruction.
//
// Ports:
//   clk          in   1     clock, all state updates on rising edge
//   reset        in   1     synchronous, active-high reset
//   stall        in   1     hazard-unit stall; hold PC and IF/ID
//   PcSel        in   1     branch unit: redirect taken this cycle
//   BrPC         in   32    branch unit: redirect target
//   halt_req     in   1     decode saw halt instruction (level)
//   instr_in     in   32    instruction memory data for pc_out (same cycle)
//   pc_out       out  PC_W  current PC / instruction-memory byte address
//   if_id_pc     out  PC_W  PC of instruction held in IF/ID
//   if_id_instr  out  32    instruction held in IF/ID
//   if_id_valid  out  1     IF/ID holds a real (non-bubble) instruction
//   halted       out  1     sticky: core has drained and stopped fetching
//   fetch_count  out  32    count of valid instructions loaded into IF/ID
// -----------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter int          PC_W       = 9,
  parameter int          HALT_DRAIN = 2,             // 1..15
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013  // addi x0,x0,0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            PcSel,
  input  logic [31:0]     BrPC,
  input  logic            halt_req,
  input  logic [31:0]     instr_in,
  output logic [PC_W-1:0] pc_out,
  output logic [PC_W-1:0] if_id_pc,
  output logic [31:0]     if_id_instr,
  output logic            if_id_valid,
  output logic            halted,
  output logic [31:0]     fetch_count
);

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } state_t;

  localparam logic [PC_W-1:0] PC_STEP    = PC_W'(4);
  localparam logic [3:0]      DRAIN_INIT = 4'(HALT_DRAIN);

  state_t          state;
  logic [3:0]      drain_cnt;
  logic [PC_W-1:0] redirect_pc;

  // Redirect targets are word aligned; the byte-offset bits and everything
  // above the PC width are dropped.
  assign redirect_pc = {BrPC[PC_W-1:2], 2'b00};

  // Discarded BrPC bits, gathered so they are visibly intentional.
  logic unused_br_bits;
  assign unused_br_bits = ^{BrPC[31:PC_W], BrPC[1:0]};

  // NOTE: every register here is written with non-blocking assignments so
  // that all reads in this block see the pre-edge values (e.g. if_id_pc takes
  // the old pc_out while pc_out advances on the same edge).
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_RUN;
      drain_cnt   <= '0;
      pc_out      <= '0;
      if_id_pc    <= '0;
      if_id_instr <= NOP_INSTR;
      if_id_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_count <= '0;
    end else begin
      case (state)
        ST_RUN: begin
          if (PcSel) begin
            // Redirect beats stall and halt_req: anything fetched or decoded
            // this cycle is on the wrong path.
            pc_out      <= redirect_pc;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end else if (stall) begin
            // Hold PC, IF/ID and fetch_count; a pending halt_req waits too.
          end else if (halt_req) begin
            // Stop fetching; the halt itself sits in decode, so IF/ID gets a
            // bubble while older instructions drain from later stages.
            state       <= ST_DRAIN;
            drain_cnt   <= DRAIN_INIT;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end else begin
            if_id_pc    <= pc_out;
            if_id_instr <= instr_in;
            if_id_valid <= 1'b1;
            pc_out      <= pc_out + PC_STEP;
            fetch_count <= fetch_count + 32'd1;
          end
        end

        ST_DRAIN: begin
          if (PcSel) begin
            // An older branch resolved taken, so the halt was speculative.
            state       <= ST_RUN;
            drain_cnt   <= '0;
            pc_out      <= redirect_pc;
            if_id_pc    <= '0;
            if_id_instr <= NOP_INSTR;
            if_id_valid <= 1'b0;
          end else if (drain_cnt <= 4'd1) begin
            // The <= also catches a zero count so the drain can never stick.
            state     <= ST_HALTED;
            drain_cnt <= '0;
            halted    <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 4'd1;
          end
        end

        ST_HALTED: begin
          // Frozen until reset.
        end

        // NOTE: the unused state encoding recovers to RUN rather than
        // falling through silently, so a corrupted state cannot lock up fetch.
        default: begin
          state     <= ST_RUN;
          drain_cnt <= '0;
        end
      endcase
    end
  end

endmodule
